mc_ctrl_fsm: RTL

- Multi-cycle CPU main controller: the initiator side of the unified register file interface.
- Drives the register file's read/write select (reg_wr) and destination select (reg_dst), plus the datapath muxes, ALU op, memory strobes and PC enables.
- Decodes opcode/funct from the instruction register.
- Supported subset: R-type (add/sub/and/or/slt), addi, lw, sw, beq, j.
- Also counts retired instructions.

---
 rtl/mc_ctrl_fsm_if.sv | 41 ++++
 rtl/mc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Controller-side bundle of the multi-cycle CPU: instruction fields and
// handshakes coming in, datapath/register-file controls going out.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             ir_wr;
    logic             i_or_d;
    logic             mem_rd;
    logic             mem_wr;
    logic             reg_wr;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       pc_src;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    // Controller (initiator) view
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
               illegal, state, instr_cnt
    );

    // Datapath / register file view
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src,
               illegal, state, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main controller. Moore-decoded control outputs from the
// state register (pc_en/ir_wr additionally gated by mem_ready/zero) and a
// retired-instruction counter.
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mc_ctrl_fsm_if.master        ctrl_if
);

    typedef enum logic [3:0] {
        ST_INIT    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC    = 4'd7,
        ST_RWB     = 4'd8,
        ST_BRANCH  = 4'd9,
        ST_JUMP    = 4'd10,
        ST_ADDIEX  = 4'd11,
        ST_ADDIWB  = 4'd12,
        ST_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True when funct names one of the supported R-type operations
    function automatic logic funct_legal(input logic [5:0] fn);
        logic ok;
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // ALU operation for an R-type funct field
    function automatic logic [2:0] funct_to_alu(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pc_en_s, ir_wr_s, i_or_d_s, mem_rd_s, mem_wr_s;
    logic             reg_wr_s, reg_dst_s, mem_to_reg_s, alu_src_a_s;
    logic [1:0]       alu_src_b_s, pc_src_s;
    logic [2:0]       alu_ctrl_s;
    logic             illegal_s;
    logic             retire_s;

    // State and retired-instruction counter registers; reset overrides all
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, Moore output decode and retirement detection
    always_comb begin
        state_d      = state_q;
        pc_en_s      = 1'b0;
        ir_wr_s      = 1'b0;
        i_or_d_s     = 1'b0;
        mem_rd_s     = 1'b0;
        mem_wr_s     = 1'b0;
        reg_wr_s     = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = 2'b00;
        alu_ctrl_s   = ALU_ADD;
        pc_src_s     = 2'b00;
        illegal_s    = 1'b0;
        retire_s     = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd_s    = 1'b1;
                alu_src_b_s = 2'b01;
                ir_wr_s     = ctrl_if.mem_ready;
                pc_en_s     = ctrl_if.mem_ready;
                if (ctrl_if.mem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                alu_src_b_s = 2'b11;
                case (ctrl_if.opcode)
                    OP_RTYPE: begin
                        if (funct_legal(ctrl_if.funct)) begin
                            state_d = ST_EXEC;
                        end else begin
                            state_d = ST_ILLEGAL;
                        end
                    end
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    default:      state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (ctrl_if.opcode == OP_LW) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_MEMWR;
                end
            end
            ST_MEMRD: begin
                mem_rd_s = 1'b1;
                i_or_d_s = 1'b1;
                if (ctrl_if.mem_ready) begin
                    state_d = ST_MEMWB;
                end else begin
                    state_d = ST_MEMRD;
                end
            end
            ST_MEMWB: begin
                reg_wr_s     = 1'b1;
                reg_dst_s    = 1'b1;
                mem_to_reg_s = 1'b1;
                state_d      = ST_FETCH;
                retire_s     = 1'b1;
            end
            ST_MEMWR: begin
                mem_wr_s = 1'b1;
                i_or_d_s = 1'b1;
                if (ctrl_if.mem_ready) begin
                    state_d  = ST_FETCH;
                    retire_s = 1'b1;
                end else begin
                    state_d  = ST_MEMWR;
                end
            end
            ST_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = funct_to_alu(ctrl_if.funct);
                state_d     = ST_RWB;
            end
            ST_RWB: begin
                reg_wr_s = 1'b1;
                state_d  = ST_FETCH;
                retire_s = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_ctrl_s  = ALU_SUB;
                pc_src_s    = 2'b01;
                pc_en_s     = ctrl_if.zero;
                state_d     = ST_FETCH;
                retire_s    = 1'b1;
            end
            ST_JUMP: begin
                pc_src_s = 2'b10;
                pc_en_s  = 1'b1;
                state_d  = ST_FETCH;
                retire_s = 1'b1;
            end
            ST_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                state_d     = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                reg_wr_s  = 1'b1;
                reg_dst_s = 1'b1;
                state_d   = ST_FETCH;
                retire_s  = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal_s = 1'b1;
                state_d   = ST_ILLEGAL;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Counter next value; wraps naturally at 2^CNT_W
    always_comb begin
        if (retire_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign ctrl_if.pc_en      = pc_en_s;
    assign ctrl_if.ir_wr      = ir_wr_s;
    assign ctrl_if.i_or_d     = i_or_d_s;
    assign ctrl_if.mem_rd     = mem_rd_s;
    assign ctrl_if.mem_wr     = mem_wr_s;
    assign ctrl_if.reg_wr     = reg_wr_s;
    assign ctrl_if.reg_dst    = reg_dst_s;
    assign ctrl_if.mem_to_reg = mem_to_reg_s;
    assign ctrl_if.alu_src_a  = alu_src_a_s;
    assign ctrl_if.alu_src_b  = alu_src_b_s;
    assign ctrl_if.alu_ctrl   = alu_ctrl_s;
    assign ctrl_if.pc_src     = pc_src_s;
    assign ctrl_if.illegal    = illegal_s;
    assign ctrl_if.state      = state_q;
    assign ctrl_if.instr_cnt  = cnt_q;

endmodule
